btb_predictor: RTL and testbench

Parametrised branch target buffer with 2-bit saturating direction counters, sitting between the IF stage and pc_reg. Each cycle it looks up the fetch PC combinationally and supplies the next fetch address plus a taken/not-taken prediction to IF/ID. EX writes back resolved branch outcomes one per cycle. Two free-running statistics counters expose resolved-branch and mispredict counts.

---
 rtl/btb_predictor.sv | 102 ++++++++++
 tb/tb_btb_predictor.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/btb_predictor.sv
// Branch target buffer with 2-bit saturating direction counters between IF and pc_reg.
// Latency: lookup is combinational (0 cycles); EX updates are visible from the next cycle.
// Backpressure: none; accepts one lookup and one resolved-branch update every cycle.
module btb_predictor #(
  parameter int          ADDR_WIDTH = 32,
  parameter int          INDEX_BITS = 8,
  parameter logic [1:0]  CNT_ALLOC  = 2'b10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] pc,
  output logic [ADDR_WIDTH-1:0] _pc,
  output logic                  prediction,
  input  logic                  br_update,
  input  logic                  br,
  input  logic [ADDR_WIDTH-1:0] br_address,
  input  logic [ADDR_WIDTH-1:0] br_pc,
  input  logic                  br_mispredict,
  output logic [31:0]           stat_branches,
  output logic [31:0]           stat_mispredicts
);

  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam int TAG_W   = ADDR_WIDTH - INDEX_BITS - 2;
  localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(4);

  // Table storage; tag/target are only meaningful where valid is set.
  logic                  valid_q  [ENTRIES];
  logic [1:0]            cnt_q    [ENTRIES];
  logic [TAG_W-1:0]      tag_q    [ENTRIES];
  logic [ADDR_WIDTH-1:0] target_q [ENTRIES];

  // Word-aligned PCs: the two low address bits never select anything.
  logic                  unused_low_bits;
  assign unused_low_bits = ^{pc[1:0], br_pc[1:0]};

  logic [INDEX_BITS-1:0] lu_idx;
  logic [TAG_W-1:0]      lu_tag;
  logic                  lu_hit;
  logic [INDEX_BITS-1:0] up_idx;
  logic [TAG_W-1:0]      up_tag;
  logic                  up_hit;

  assign lu_idx = pc[INDEX_BITS+1:2];
  assign lu_tag = pc[ADDR_WIDTH-1:INDEX_BITS+2];
  assign up_idx = br_pc[INDEX_BITS+1:2];
  assign up_tag = br_pc[ADDR_WIDTH-1:INDEX_BITS+2];

  assign lu_hit = valid_q[lu_idx] && (tag_q[lu_idx] == lu_tag);
  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  // Lookup: redirect to stored target only on a hit with a taken-leaning counter.
  always_comb begin
    prediction = 1'b0;
    _pc        = '0;
    if (!rst) begin
      prediction = lu_hit && cnt_q[lu_idx][1];
      _pc        = prediction ? target_q[lu_idx] : (pc + PC_STEP);
    end
  end

  // Valid bits and direction counters: reset clears, updates train or allocate.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        cnt_q[i]   <= 2'b00;
      end
    end else if (br_update) begin
      if (up_hit) begin
        if (br) begin
          if (cnt_q[up_idx] != 2'b11) cnt_q[up_idx] <= cnt_q[up_idx] + 2'b01;
        end else begin
          if (cnt_q[up_idx] != 2'b00) cnt_q[up_idx] <= cnt_q[up_idx] - 2'b01;
        end
      end else if (br) begin
        valid_q[up_idx] <= 1'b1;
        cnt_q[up_idx]   <= CNT_ALLOC;
      end
    end
  end

  // Tag/target payload: every taken resolution writes it (hit refresh or allocation).
  always_ff @(posedge clk) begin
    if (!rst && br_update && br) begin
      tag_q[up_idx]    <= up_tag;
      target_q[up_idx] <= br_address;
    end
  end

  // Free-running statistics; mispredict flag only counts alongside an update.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else if (br_update) begin
      stat_branches <= stat_branches + 32'd1;
      if (br_mispredict) stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end

endmodule

// File: tb/tb_btb_predictor.sv
// Directed bench for btb_predictor with an expected-result queue per step.
// Latency: checks combinational outputs mid-cycle, updates land at the next rising edge.
// Backpressure: not applicable; one step per clock.
module tb_btb_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic [31:0] _pc;
  logic        prediction;
  logic        br_update;
  logic        br;
  logic [31:0] br_address;
  logic [31:0] br_pc;
  logic        br_mispredict;
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       tag;
    logic        pred;
    logic [31:0] npc;
    logic        chk_stats;
    logic [31:0] sb;
    logic [31:0] sm;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] m_br;
  logic [31:0] m_mis;
  logic        stats_known = 1'b0;

  btb_predictor #(.ADDR_WIDTH(32), .INDEX_BITS(8), .CNT_ALLOC(2'b10)) dut (
    .clk              (clk),
    .rst              (rst),
    .pc               (pc),
    ._pc              (_pc),
    .prediction       (prediction),
    .br_update        (br_update),
    .br               (br),
    .br_address       (br_address),
    .br_pc            (br_pc),
    .br_mispredict    (br_mispredict),
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
  );

  always #5 clk = ~clk;

  // Drive one cycle of stimulus at the falling edge, queue the expectation,
  // then pop and compare shortly after; the next rising edge applies any update.
  task automatic step(input string tg, input logic r, input logic [31:0] p,
                      input logic upd, input logic b, input logic [31:0] bpc,
                      input logic [31:0] baddr, input logic mis,
                      input logic epred, input logic [31:0] enpc);
    exp_t e;
    @(negedge clk);
    rst = r; pc = p; br_update = upd; br = b; br_pc = bpc;
    br_address = baddr; br_mispredict = mis;
    e.tag = tg; e.pred = epred; e.npc = enpc;
    e.chk_stats = stats_known; e.sb = m_br; e.sm = m_mis;
    sb_q.push_back(e);
    if (r) begin
      m_br = '0; m_mis = '0; stats_known = 1'b1;
    end else if (upd) begin
      m_br = m_br + 32'd1;
      if (mis) m_mis = m_mis + 32'd1;
    end
    #1;
    e = sb_q.pop_front();
    checks++;
    assert (prediction === e.pred) else begin
      errors++;
      $error("FAIL %s prediction observed=%0b expected=%0b", e.tag, prediction, e.pred);
    end
    checks++;
    assert (_pc === e.npc) else begin
      errors++;
      $error("FAIL %s _pc observed=%h expected=%h", e.tag, _pc, e.npc);
    end
    if (e.chk_stats) begin
      checks++;
      assert (stat_branches === e.sb) else begin
        errors++;
        $error("FAIL %s stat_branches observed=%0d expected=%0d", e.tag, stat_branches, e.sb);
      end
      checks++;
      assert (stat_mispredicts === e.sm) else begin
        errors++;
        $error("FAIL %s stat_mispredicts observed=%0d expected=%0d", e.tag, stat_mispredicts, e.sm);
      end
    end
  endtask

  initial begin
    rst = 1'b1; pc = '0; br_update = 1'b0; br = 1'b0; br_pc = '0;
    br_address = '0; br_mispredict = 1'b0; m_br = '0; m_mis = '0;

    // Reset and first lookups
    step("rst_hold",    1, 32'h100, 0, 0, 32'h0,   32'h0,   0, 0, 32'h0);
    step("alloc",       0, 32'h100, 1, 1, 32'h100, 32'h200, 0, 0, 32'h104);
    step("hit",         0, 32'h100, 0, 0, 32'h0,   32'h0,   0, 1, 32'h200);
    // Alias on same index, different tag; train not-taken (10 -> 01)
    step("alias_miss",  0, 32'h500, 1, 0, 32'h100, 32'h0,   1, 0, 32'h504);
    step("cnt01",       0, 32'h100, 1, 0, 32'h100, 32'h0,   0, 0, 32'h104);
    step("cnt00",       0, 32'h100, 1, 0, 32'h100, 32'h0,   0, 0, 32'h104);
    step("sat00",       0, 32'h100, 1, 1, 32'h100, 32'h200, 0, 0, 32'h104);
    step("from00_01",   0, 32'h100, 1, 1, 32'h100, 32'h200, 1, 0, 32'h104);
    step("cnt10",       0, 32'h100, 1, 1, 32'h100, 32'h240, 0, 1, 32'h200);
    step("cnt11_tgt",   0, 32'h100, 1, 1, 32'h100, 32'h240, 0, 1, 32'h240);
    step("sat11",       0, 32'h100, 1, 0, 32'h100, 32'h0,   0, 1, 32'h240);
    step("back10",      0, 32'h100, 0, 0, 32'h0,   32'h0,   0, 1, 32'h240);
    // Not-taken miss never allocates; same-cycle lookup sees old contents
    step("nt_miss",     0, 32'h300, 1, 0, 32'h300, 32'h700, 0, 0, 32'h304);
    step("same_cyc",    0, 32'h300, 1, 1, 32'h300, 32'h700, 0, 0, 32'h304);
    step("mis_no_upd",  0, 32'h303, 0, 0, 32'h0,   32'h0,   1, 1, 32'h700);
    step("indep_idx",   0, 32'h100, 1, 1, 32'h400, 32'h800, 1, 1, 32'h240);
    step("new_entry",   0, 32'h400, 0, 0, 32'h0,   32'h0,   0, 1, 32'h800);
    step("pc_wrap",     0, 32'hFFFFFFFC, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0);

    // Fresh stats run: 5 updates, 2 mispredicts, plus a lone mispredict flag
    step("rst2",        1, 32'h100, 0, 0, 32'h0,   32'h0,   0, 0, 32'h0);
    step("st1",         0, 32'h100, 1, 0, 32'h600, 32'h0,   1, 0, 32'h104);
    step("st2",         0, 32'h100, 1, 0, 32'h600, 32'h0,   0, 0, 32'h104);
    step("st_lone",     0, 32'h100, 0, 0, 32'h600, 32'h0,   1, 0, 32'h104);
    step("st3",         0, 32'h100, 1, 0, 32'h600, 32'h0,   1, 0, 32'h104);
    step("st4",         0, 32'h100, 1, 0, 32'h600, 32'h0,   0, 0, 32'h104);
    step("st5",         0, 32'h100, 1, 0, 32'h600, 32'h0,   0, 0, 32'h104);
    step("st_total",    0, 32'h100, 0, 0, 32'h0,   32'h0,   0, 0, 32'h104);
    checks++;
    assert (stat_branches === 32'd5 && stat_mispredicts === 32'd2) else begin
      errors++;
      $error("FAIL stats_abs observed=%0d/%0d expected=5/2", stat_branches, stat_mispredicts);
    end

    // Counter wrap: preload all-ones, one update rolls to zero
    @(negedge clk);
    force dut.stat_branches = 32'hFFFFFFFF;
    #1 release dut.stat_branches;
    m_br = 32'hFFFFFFFF;
    step("wrap_pre",    0, 32'h100, 1, 0, 32'h600, 32'h0,   0, 0, 32'h104);
    step("wrap_zero",   0, 32'h100, 0, 0, 32'h0,   32'h0,   0, 0, 32'h104);

    // Reset wins over a concurrent allocating update
    step("rst_prio",    1, 32'h100, 1, 1, 32'h100, 32'h200, 1, 0, 32'h0);
    step("after_rst",   0, 32'h100, 0, 0, 32'h0,   32'h0,   0, 0, 32'h104);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
